// File: rtl/curl_job_scheduler.sv
// Round-robin job scheduler that programs a shared curl accelerator over Avalon-MM,
// then polls its finish flag and reports completion or poll timeout to the granted requester.
module curl_job_scheduler #(
  parameter int          N_REQ     = 4,
  parameter int          ID_W      = 2,
  parameter int          POLL_GAP  = 4,
  parameter logic [15:0] MAX_POLLS = 16'd4096
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [32*N_REQ-1:0]   i_req_src,
  input  logic [32*N_REQ-1:0]   i_req_dst,
  input  logic [16*N_REQ-1:0]   i_req_len,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic                  o_done_valid,
  output logic [ID_W-1:0]       o_done_id,
  output logic                  o_done_err,
  output logic                  o_busy,
  output logic [1:0]            o_csr_address,
  output logic                  o_csr_write,
  output logic                  o_csr_read,
  output logic [31:0]           o_csr_writedata,
  output logic [3:0]            o_csr_byteenable,
  input  logic [31:0]           i_csr_readdata,
  input  logic                  i_csr_waitrequest,
  input  logic                  i_csr_readdatavalid
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    IDLE, GRANT, WR_SRC, WR_DST, WR_OP, GAP, RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       poll_q, poll_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              err_q, err_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic              eval;
  logic [15:0]       poll_eval;
  logic              unused_rd;

  assign unused_rd = ^i_csr_readdata[31:1];

  // Scan downwards so the valid requester closest to rr_ptr is the one left standing.
  always_comb begin : rr_pick
    logic [ID_W-1:0] idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (i_req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    rr_ptr_d  = rr_ptr_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    err_d     = err_q;
    eval      = 1'b0;
    poll_eval = poll_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gid_d   = pick_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        src_d    = i_req_src[{gid_q, 5'b0} +: 32];
        dst_d    = i_req_dst[{gid_q, 5'b0} +: 32];
        len_d    = i_req_len[{gid_q, 4'b0} +: 16];
        rr_ptr_d = (int'(gid_q) == N_REQ - 1) ? '0 : gid_q + 1'b1;
        state_d  = WR_SRC;
      end
      WR_SRC: if (!i_csr_waitrequest) state_d = WR_DST;
      WR_DST: if (!i_csr_waitrequest) state_d = WR_OP;
      WR_OP: begin
        if (!i_csr_waitrequest) begin
          poll_d  = '0;
          gap_d   = GAP_W'(POLL_GAP);
          err_d   = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) state_d = RD_REQ;
      end
      RD_REQ: begin
        if (!i_csr_waitrequest) begin
          poll_d    = poll_q + 16'd1;
          poll_eval = poll_q + 16'd1;
          if (i_csr_readdatavalid) eval = 1'b1;
          else                     state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (i_csr_readdatavalid) eval = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Finish wins over timeout when both land on the last allowed poll.
    if (eval) begin
      if (i_csr_readdata[0]) begin
        err_d   = 1'b0;
        state_d = DONE;
      end else if (poll_eval == MAX_POLLS) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        gap_d   = GAP_W'(POLL_GAP);
        state_d = GAP;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      rr_ptr_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      poll_q   <= '0;
      gap_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
    end
  end

  // Outputs depend only on state and captured registers, so stalls keep them stable.
  always_comb begin
    o_req_ready      = '0;
    o_done_valid     = 1'b0;
    o_done_id        = '0;
    o_done_err       = 1'b0;
    o_busy           = (state_q != IDLE);
    o_csr_write      = 1'b0;
    o_csr_read       = 1'b0;
    o_csr_address    = 2'd0;
    o_csr_writedata  = '0;
    o_csr_byteenable = '0;
    case (state_q)
      GRANT: o_req_ready[gid_q] = 1'b1;
      WR_SRC: begin
        o_csr_write      = 1'b1;
        o_csr_address    = 2'd1;
        o_csr_writedata  = src_q;
        o_csr_byteenable = 4'hF;
      end
      WR_DST: begin
        o_csr_write      = 1'b1;
        o_csr_address    = 2'd2;
        o_csr_writedata  = dst_q;
        o_csr_byteenable = 4'hF;
      end
      WR_OP: begin
        o_csr_write      = 1'b1;
        o_csr_address    = 2'd0;
        o_csr_writedata  = {8'h00, len_q, 8'h02};
        o_csr_byteenable = 4'b0111;
      end
      RD_REQ: begin
        o_csr_read       = 1'b1;
        o_csr_address    = 2'd0;
        o_csr_byteenable = 4'hF;
      end
      DONE: begin
        o_done_valid = 1'b1;
        o_done_id    = gid_q;
        o_done_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/curl_job_scheduler.md
# curl_job_scheduler

Shares one curl accelerator among `N_REQ` requesters. Each requester presents a job descriptor (source word address, destination word address, length in trits). The block arbitrates round-robin and programs the accelerator's 32-bit CSR slave through its own Avalon-MM master. It then polls the finish flag and reports completion, or a poll timeout, back to the granted requester.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: width of requester index; equals clog2(`N_REQ`).
- `POLL_GAP`, 4: idle cycles before each status read (minimum 3).
- `MAX_POLLS`, 16'd4096: status reads before timeout.

Ports:
- `i_clk`  in  1  clock.
- `i_arst`  in  1  reset, asynchronous, active-high.
- `i_req_valid`  in  N_REQ  per-requester job request.
- `i_req_src`  in  32*N_REQ  source word address, slice r at [32r +: 32].
- `i_req_dst`  in  32*N_REQ  destination word address.
- `i_req_len`  in  16*N_REQ  source length in trits.
- `o_req_ready`  out  N_REQ  one-hot, one-cycle descriptor accept.
- `o_done_valid`  out  1  one-cycle completion pulse.
- `o_done_id`  out  ID_W  requester index of the completed job.
- `o_done_err`  out  1  high with `o_done_valid` on poll timeout.
- `o_busy`  out  1  high when the FSM is not in `IDLE`.
- `o_csr_address`  out  2  accelerator CSR word: 0 op, 1 src, 2 dst.
- `o_csr_write`  out  1  CSR write request.
- `o_csr_read`  out  1  CSR read request.
- `o_csr_writedata`  out  32  CSR write data.
- `o_csr_byteenable`  out  4  CSR byte enables.
- `i_csr_readdata`  in  32  CSR read data.
- `i_csr_waitrequest`  in  1  CSR stall.
- `i_csr_readdatavalid`  in  1  CSR read data valid.

## Operation
- FSM states: `IDLE`, `GRANT`, `WR_SRC`, `WR_DST`, `WR_OP`, `GAP`, `RD_REQ`, `RD_WAIT`, `DONE`.
- `IDLE`:
  - If any `i_req_valid` bit is set, go to `GRANT`.
  - Round-robin: grant the first valid index at or after `rr_ptr`, wrapping modulo `N_REQ`.
- `GRANT`:
  - Assert `o_req_ready[g]` for exactly one cycle.
  - Capture src, dst, len and g.
  - Set `rr_ptr` to (g+1) mod `N_REQ`.
  - Go to `WR_SRC`.
  - Requesters hold valid and data stable until they see ready. A valid that drops before grant is simply skipped.
- `WR_SRC`:
  - Address 1, data src, byteenable 4'hF.
  - `o_csr_write` stays high until a cycle with `i_csr_waitrequest`=0, then go to `WR_DST`.
- `WR_DST`: address 2, data dst, byteenable 4'hF; same hold rule, then `WR_OP`.
- `WR_OP`:
  - Address 0, data {8'h00, len, 8'h02} (start bit1), byteenable 4'b0111.
  - On accept, clear the poll counter, load the gap counter with `POLL_GAP`, go to `GAP`.
- `GAP`:
  - Decrement the gap counter; go to `RD_REQ` at zero.
  - The gap exists because the accelerator's stale finish bit is only cleared 2 cycles after the start write.
- `RD_REQ`:
  - Address 0, `o_csr_read` held until `i_csr_waitrequest`=0; increment the poll counter.
  - If `i_csr_readdatavalid` is high in the accept cycle, evaluate the data immediately. Otherwise go to `RD_WAIT`.
- `RD_WAIT`: wait for `i_csr_readdatavalid`, then evaluate.
- Evaluate read data:
  - `readdata[0]`=1: go to `DONE` with err=0.
  - Poll counter == `MAX_POLLS`: go to `DONE` with err=1.
  - Otherwise reload the gap counter and go to `GAP`.
- `DONE`:
  - `o_done_valid`=1, `o_done_id`=g, `o_done_err` as latched.
  - Go to `IDLE`. A new grant may occur on the next cycle.
- Only one job is in flight; other requesters wait with valid high.
- Length is passed unmodified; 0 is legal.
- `o_csr_write` and `o_csr_read` are never high in the same cycle.

## Timing
- Reset values:
  - `o_req_ready`=0, `o_done_valid`=0, `o_done_id`=0, `o_done_err`=0, `o_busy`=0.
  - `o_csr_write`=0, `o_csr_read`=0, `o_csr_address`=0, `o_csr_writedata`=0, `o_csr_byteenable`=0.
  - `rr_ptr`=0, state `IDLE`.
- All outputs are registered or decoded from state only; none is combinational from inputs.
- Zero-wait latency with request valid at cycle 0:
  - `GRANT`/ready at cycle 1.
  - Src write at cycle 2, dst at 3, op at 4.
  - First read at 5+`POLL_GAP`.
  - `o_done_valid` 1 cycle after finish data is seen (if readdatavalid comes with the accept).
- Each wait-request cycle extends the corresponding state by exactly one cycle; address, data and byteenable are stable while stalled.
- Reset mid-job returns to `IDLE` immediately; no completion is reported for the aborted job.
- A valid that rises during `DONE` is granted at the earliest in `GRANT`, 2 cycles later.

## Test plan
- Single job:
  - Stimulus: req0 valid, src=0x100, dst=0x200, len=243, finish returns 1 on the 2nd poll.
  - Response: writes (1,0x100), (2,0x200), (0,0x00F302) with BE 0111; 2 reads; `o_done_valid` with id=0, err=0.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously.
  - Response: grant order 0,1,2,3,0; with req1 and req3 only, order 1,3,1.
- Waitrequest:
  - Stimulus: hold `i_csr_waitrequest` 3 cycles on each access.
  - Response: each write/read is held 4 cycles with stable address and data; exactly one accept per access.
- Timeout:
  - Stimulus: `MAX_POLLS`=3, finish never set.
  - Response: exactly 3 reads, then `o_done_err`=1 with the correct id.
- Stale finish / reset:
  - Stimulus: finish=1 already before the start write, and separately `i_arst` asserted in `GAP`.
  - Response: no read issued earlier than `POLL_GAP` cycles after the op accept; after reset all outputs are 0 and no `o_done_valid` appears.
